afifo_wr_arb: RTL
=================

# afifo_wr_arb

Write-side arbiter for the async FIFO. Shares the FIFO write port (`wr_en`/`wdata`, qualified by `wr_full`) among `REQ_NUM` requesters in the `clk_wr` domain. Grants are round-robin and burst-based: a granted requester keeps the port until it marks a last beat or hits `BURST_MAX` beats. The block sits between the write-domain producers and the FIFO write interface.

## Interface
- `DATA_WIDTH`, 32: beat width; must equal the FIFO data width.
- `REQ_NUM`, 4: number of requesters; ≥2. `GNT_W = $clog2(REQ_NUM)`.
- `BURST_MAX`, 4: maximum beats per grant; ≥1. `BCNT_W = $clog2(BURST_MAX+1)`.

Ports:
- `clk_wr` in 1: write-domain clock; the only clock.
- `rst_wr_n` in 1: reset, synchronous, active-low.
- `req_valid` in REQ_NUM: per-requester beat valid.
- `req_last` in REQ_NUM: per-requester last-beat marker; qualified by that requester's valid.
- `req_data` in REQ_NUM*DATA_WIDTH: requester i drives slice `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_ready` out REQ_NUM: per-requester beat accept; combinational.
- `wr_full` in 1: FIFO full flag, registered by the FIFO.
- `wr_en` out 1: FIFO write strobe; combinational.
- `wdata` out DATA_WIDTH: FIFO write data; combinational mux of the granted slice.
- `gnt_id` out GNT_W: current or last grant index; registered.
- `busy` out 1: high while in GRANT; registered.

## Operation
- FSM has two states, IDLE and GRANT. Reset state is IDLE.
- **IDLE:**
  - If `|req_valid` is set, select the first valid requester scanning upward from `(rr_ptr+1) mod REQ_NUM`.
  - Next edge: load `gnt_id`, set `rr_ptr <= selected`, clear `beat_cnt`, go to GRANT.
  - If no requester is valid, stay in IDLE.
- **GRANT:**
  - `req_ready[gnt_id] = ~wr_full`. All other `req_ready` bits are 0.
  - A beat occurs when `req_valid[gnt_id] && req_ready[gnt_id]`. On a beat, `wr_en = 1` and `wdata = req_data[gnt_id]`.
  - On each beat, `beat_cnt` increments.
  - Return to IDLE on the edge of a beat where `req_last[gnt_id]` is set, or where `beat_cnt+1 == BURST_MAX`.
  - If both conditions hit on the same beat, release once; there is no double action.
  - If `req_valid[gnt_id]` is low, the grant is held and no beat occurs. The requester owns the port until it sends last or reaches the burst limit.
- **Full:** while `wr_full=1`, no beat occurs, `beat_cnt` is frozen and the grant is held. Writes resume on the first cycle with `wr_full=0`.
- The block never asserts `wr_en` while `wr_full=1`.
- In IDLE, `wr_en=0` and `req_ready` is all zeros.
- **Arithmetic and widths:**
  - `rr_ptr` is GNT_W bits, modulo REQ_NUM. For non-power-of-2 REQ_NUM, wrap explicitly from REQ_NUM-1 to 0.
  - `beat_cnt` is BCNT_W bits and never exceeds BURST_MAX-1 while in GRANT.
- **Reset values:**
  - state IDLE, `gnt_id=0`, `busy=0`, `beat_cnt=0`.
  - `rr_ptr=REQ_NUM-1`, so requester 0 has first priority.
  - `wr_en=0` and `req_ready=0` as a consequence of IDLE.
- **Reset mid-burst:** on the reset edge, return to IDLE. The partial burst is abandoned; the remaining beats are the requester's responsibility. The FIFO has its own reset and is not touched.
- **Re-grant:** a lone requester that stays valid is re-granted after each release, with one IDLE cycle in between.

## Timing
- Arbitration latency is 1 cycle. `req_valid` rising in IDLE at edge N gives `busy=1`, `gnt_id` valid, and `req_ready` possible in cycle N+1.
- There is a 1-cycle IDLE bubble between consecutive grants.
- Peak throughput is BURST_MAX beats per BURST_MAX+1 cycles.
- `req_valid` → `wr_en` and `req_data` → `wdata` are combinational within the same cycle. The FIFO samples them at the next `clk_wr` edge.
- `req_ready` depends on `wr_full` and registered state only. It has no combinational path from `req_valid`.
- `busy` and `gnt_id` update on the edge after the deciding event.

## Test plan
Parameters for all cases: REQ_NUM=4, BURST_MAX=4, DATA_WIDTH=32.

1. **Reset:** hold `rst_wr_n=0` for 3 cycles with `req_valid=4'b1111` → `wr_en=0`, `req_ready=0`, `busy=0`, `gnt_id=0`. Release reset → first grant is `gnt_id=0` one cycle later.
2. **Round-robin:** all 4 requesters valid continuously, `req_last=0`, data `=0xA0+i*16+beat` → grant order 0,1,2,3,0. Each grant writes exactly 4 beats with one IDLE cycle between grants. `wdata` sequence is 0xA0..0xA3, 0xB0..0xB3, and so on.
3. **Early last:** requester 1 asserts `req_last` on its 2nd beat, others valid → requester 1 writes 2 beats, then the next grant goes to requester 2.
4. **Full stall:** `wr_full=1` for 3 cycles after beat 2 of a grant → `wr_en=0` and `req_ready=0` for those 3 cycles, `gnt_id` unchanged. Beats 3 and 4 follow after `wr_full` falls, for 4 beats total.
5. **Reset mid-burst:** assert reset after beat 2 of the grant to requester 2 → `wr_en=0` and `busy=0` after the reset edge. After release, requester 0 is granted first.
6. **Single requester:** only requester 3 valid, `req_last` on every beat → re-granted every other cycle, pattern beat/IDLE, `gnt_id=3` throughout.

Source files
------------

// File: rtl/afifo_wr_arb.sv
// afifo_wr_arb: round-robin, burst-based write-port arbiter
// Shares one async-FIFO write port among REQ_NUM clk_wr producers.
module afifo_wr_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int REQ_NUM    = 4,
    parameter int BURST_MAX  = 4,
    parameter int GNT_W      = $clog2(REQ_NUM),
    parameter int BCNT_W     = $clog2(BURST_MAX + 1)
) (
    input  logic                          clk_wr,
    input  logic                          rst_wr_n,
    input  logic [REQ_NUM-1:0]            req_valid,
    input  logic [REQ_NUM-1:0]            req_last,
    input  logic [REQ_NUM*DATA_WIDTH-1:0] req_data,
    output logic [REQ_NUM-1:0]            req_ready,
    input  logic                          wr_full,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic [GNT_W-1:0]              gnt_id,
    output logic                          busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [GNT_W-1:0]    gnt_q, gnt_d;
    logic [GNT_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [BCNT_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic [GNT_W-1:0]    sel;
    logic [GNT_W-1:0]    cand;
    logic                found;
    logic                beat;
    logic                release_now;

    // first valid requester after the last winner, wrapping modulo REQ_NUM
    always_comb begin
        sel   = rr_ptr_q;
        cand  = rr_ptr_q;
        found = 1'b0;
        for (int k = 1; k <= REQ_NUM; k++) begin
            cand = GNT_W'((int'(rr_ptr_q) + k) % REQ_NUM);
            if (!found && req_valid[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    // write-port mux and ready fan-out; ready never looks at req_valid
    always_comb begin
        wdata     = '0;
        req_ready = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (gnt_q == GNT_W'(i)) begin
                wdata        = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                req_ready[i] = (state_q == GRANT) && !wr_full;
            end
        end
    end

    assign beat        = (state_q == GRANT) && !wr_full && req_valid[gnt_q];
    assign release_now = beat && (req_last[gnt_q] ||
                         (beat_cnt_q == BCNT_W'(BURST_MAX - 1)));
    assign wr_en       = beat;
    assign gnt_id      = gnt_q;
    assign busy        = (state_q == GRANT);

    // next-state: arbitrate in IDLE, count beats and release in GRANT
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d    = GRANT;
                    gnt_d      = sel;
                    rr_ptr_d   = sel;
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_d    = IDLE;
                    beat_cnt_d = '0;
                end else if (beat) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state register; rr_ptr resets to the top so requester 0 wins first
    always_ff @(posedge clk_wr) begin
        if (!rst_wr_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            rr_ptr_q   <= GNT_W'(REQ_NUM - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule
